// File: rtl/npu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : npu_run_ctrl
//  Purpose  : Sequences one NPU job (init, start, run, done/abort, watchdog)
//             on the transfer clock. Optional watchdog: NPU_CTRL_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module npu_run_ctrl #(
    parameter int INIT_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk_trans,
    input  logic             rst,
    input  logic             init_go,
    input  logic             start_req,
    output logic             start_ack,
    input  logic             abort,
    output logic             npu_init_cmplt,
    output logic             npu_en_processing,
    input  logic             npu_busy_sync,
    output logic             done_pulse,
    output logic             err_timeout,
    output logic [CNT_W-1:0] run_cycles,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_READY = 3'd2,
        S_ARM   = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5,
        S_DRAIN = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] c_init_load = CNT_W'(INIT_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_init_cnt;
    logic [CNT_W-1:0] r_run_cnt;
    logic             r_start_ack;
    logic             r_init_cmplt;
    logic             r_en;
    logic             r_done;
    logic             w_wd_expired;
    logic             w_accept;

    assign w_accept = (r_state == S_READY) && (w_next == S_ARM);

`ifdef NPU_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_wd_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_err;

    // Count reaches the limit on the edge that moves us into ERR.
    assign w_wd_expired = ((r_state == S_ARM) || (r_state == S_DRAIN)) &&
                          (r_wd_cnt == c_wd_last);

    always_ff @(posedge clk_trans) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= (w_next == S_ERR);
            if ((w_next != r_state) && ((w_next == S_ARM) || (w_next == S_DRAIN)))
                r_wd_cnt <= '0;
            else if ((r_state == S_ARM) || (r_state == S_DRAIN))
                r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign err_timeout = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_wd_expired     = 1'b0;
    assign err_timeout      = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (init_go) w_next = S_INIT;
            S_INIT:  if (r_init_cnt == '0) w_next = S_READY;
            S_READY: begin
                if (init_go)        w_next = S_INIT;
                else if (start_req) w_next = S_ARM;
            end
            S_ARM: begin
                if (npu_busy_sync)     w_next = S_RUN;
                else if (abort)        w_next = S_DRAIN;
                else if (w_wd_expired) w_next = S_ERR;
            end
            // Busy falling beats a simultaneous abort.
            S_RUN: begin
                if (!npu_busy_sync) w_next = S_DONE;
                else if (abort)     w_next = S_DRAIN;
            end
            S_DONE:  w_next = S_READY;
            S_DRAIN: begin
                if (!npu_busy_sync)    w_next = S_READY;
                else if (w_wd_expired) w_next = S_ERR;
            end
            S_ERR:   if (init_go) w_next = S_INIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_trans) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_init_cnt   <= '0;
            r_run_cnt    <= '0;
            r_start_ack  <= 1'b0;
            r_init_cmplt <= 1'b0;
            r_en         <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_start_ack  <= w_accept;
            r_en         <= (w_next == S_ARM) || (w_next == S_RUN);
            r_done       <= (w_next == S_DONE);
            r_init_cmplt <= (w_next == S_READY) || (w_next == S_ARM) ||
                            (w_next == S_RUN) || (w_next == S_DONE) ||
                            (w_next == S_DRAIN);

            if ((w_next == S_INIT) && (r_state != S_INIT))
                r_init_cnt <= c_init_load;
            else if ((r_state == S_INIT) && (r_init_cnt != '0))
                r_init_cnt <= r_init_cnt - 1'b1;

            if (w_accept)
                r_run_cnt <= '0;
            else if ((r_state == S_RUN) && (r_run_cnt != '1))
                r_run_cnt <= r_run_cnt + 1'b1;
        end
    end

    assign start_ack         = r_start_ack;
    assign npu_init_cmplt    = r_init_cmplt;
    assign npu_en_processing = r_en;
    assign done_pulse        = r_done;
    assign run_cycles        = r_run_cnt;
    assign state_o           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_npu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_npu_run_ctrl
//  Purpose  : Self-checking bench for npu_run_ctrl (directed table, corner
//             sequences, randomized traffic against a reference model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_npu_run_ctrl;

    localparam int INIT_CYC = 16;
    localparam int TO_CYC   = 8;
    localparam int RUN_MAX  = 255;
`ifdef NPU_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_INIT = 1, M_READY = 2, M_ARM = 3;
    localparam int M_RUN = 4, M_DONE = 5, M_DRAIN = 6, M_ERR = 7;

    logic       clk_trans = 1'b0;
    logic       rst = 1'b1;
    logic       init_go = 1'b0;
    logic       start_req = 1'b0;
    logic       abort = 1'b0;
    logic       npu_busy_sync = 1'b0;
    logic       start_ack;
    logic       npu_init_cmplt;
    logic       npu_en_processing;
    logic       done_pulse;
    logic       err_timeout;
    logic [7:0] run_cycles;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_err = 0;

    npu_run_ctrl #(
        .INIT_CYCLES   (INIT_CYC),
        .TIMEOUT_CYCLES(TO_CYC),
        .CNT_W         (8)
    ) dut (
        .clk_trans        (clk_trans),
        .rst              (rst),
        .init_go          (init_go),
        .start_req        (start_req),
        .start_ack        (start_ack),
        .abort            (abort),
        .npu_init_cmplt   (npu_init_cmplt),
        .npu_en_processing(npu_en_processing),
        .npu_busy_sync    (npu_busy_sync),
        .done_pulse       (done_pulse),
        .err_timeout      (err_timeout),
        .run_cycles       (run_cycles),
        .state_o          (state_o)
    );

    always #5 clk_trans = ~clk_trans;

    // Reference model: phase plus elapsed-edge counts since phase entry.
    int m_mode = M_IDLE;
    int m_init_edges = 0;
    int m_wd_edges = 0;
    int m_run = 0;
    bit m_ack = 1'b0;

    task automatic model_step(input bit rs, ig, sr, ab, bz);
        m_ack = 1'b0;
        if (rs) begin
            m_mode = M_IDLE;
            m_run  = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_ERR: begin
                    if (ig) begin m_mode = M_INIT; m_init_edges = 0; end
                end
                M_INIT: begin
                    m_init_edges++;
                    if (m_init_edges == INIT_CYC) m_mode = M_READY;
                end
                M_READY: begin
                    if (ig) begin
                        m_mode = M_INIT; m_init_edges = 0;
                    end else if (sr) begin
                        m_mode = M_ARM; m_ack = 1'b1; m_run = 0; m_wd_edges = 0;
                    end
                end
                M_ARM: begin
                    m_wd_edges++;
                    if (bz)                              m_mode = M_RUN;
                    else if (ab)                         begin m_mode = M_DRAIN; m_wd_edges = 0; end
                    else if (TO_EN && m_wd_edges == TO_CYC) m_mode = M_ERR;
                end
                M_RUN: begin
                    m_run = (m_run < RUN_MAX) ? m_run + 1 : RUN_MAX;
                    if (!bz)     m_mode = M_DONE;
                    else if (ab) begin m_mode = M_DRAIN; m_wd_edges = 0; end
                end
                M_DONE: m_mode = M_READY;
                M_DRAIN: begin
                    m_wd_edges++;
                    if (!bz)                             m_mode = M_READY;
                    else if (TO_EN && m_wd_edges == TO_CYC) m_mode = M_ERR;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // Packing: {state[2:0], ack, en, done, init_cmplt, err, run[7:0]}
    function automatic logic [15:0] model_exp();
        logic [2:0] st;
        logic [4:0] fl;
        st = 3'(m_mode);
        fl = {m_ack, (m_mode == M_ARM) || (m_mode == M_RUN), m_mode == M_DONE,
              (m_mode >= M_READY) && (m_mode <= M_DRAIN), m_mode == M_ERR};
        return {st, fl, 8'(m_run)};
    endfunction

    task automatic check(input string name, input logic [15:0] exp);
        logic [15:0] act;
        act = {state_o, start_ack, npu_en_processing, done_pulse,
               npu_init_cmplt, err_timeout, run_cycles};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got state=%0d ack/en/done/cmplt/err=%b run=%0d, want state=%0d ack/en/done/cmplt/err=%b run=%0d",
                     name, act[15:13], act[12:8], act[7:0], exp[15:13], exp[12:8], exp[7:0]);
        end
    endtask

    task automatic apply(input bit rs, ig, sr, ab, bz);
        @(negedge clk_trans);
        rst = rs; init_go = ig; start_req = sr; abort = ab; npu_busy_sync = bz;
        @(posedge clk_trans);
        model_step(rs, ig, sr, ab, bz);
        #1;
    endtask

    task automatic step_chk(input string name, input bit rs, ig, sr, ab, bz);
        apply(rs, ig, sr, ab, bz);
        check(name, model_exp());
    endtask

    typedef struct packed {
        logic [7:0] n;
        logic       rs, ig, sr, ab, bz;
        logic [2:0] st;
        logic [4:0] fl;
        logic [7:0] run;
    } vec_t;

    vec_t tbl[40];
    int   ntbl = 0;

    task automatic add(input int n, input bit rs, ig, sr, ab, bz,
                       input logic [2:0] st, input logic [4:0] fl, input logic [7:0] run);
        tbl[ntbl] = {8'(n), rs, ig, sr, ab, bz, st, fl, run};
        ntbl++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, want finish before 1000000");
        $fatal(1);
    end

    initial begin
        bit rs, ig, sr, ab, bz;

        //  n  rs ig sr ab bz  st  ack/en/done/cmplt/err  run
        add( 2, 1, 0, 0, 0, 0, 3'd0, 5'b00000, 8'd0);
        add( 1, 0, 1, 0, 0, 0, 3'd1, 5'b00000, 8'd0);
        add(15, 0, 0, 0, 0, 0, 3'd1, 5'b00000, 8'd0);
        add( 1, 0, 0, 0, 0, 0, 3'd2, 5'b00010, 8'd0);
        add( 1, 0, 0, 1, 0, 0, 3'd3, 5'b11010, 8'd0);
        add( 1, 0, 0, 0, 0, 0, 3'd3, 5'b01010, 8'd0);
        add( 1, 0, 0, 0, 0, 0, 3'd3, 5'b01010, 8'd0);
        add(10, 0, 0, 0, 0, 1, 3'd4, 5'b01010, 8'd9);
        add( 1, 0, 0, 0, 0, 0, 3'd5, 5'b00110, 8'd10);
        add( 1, 0, 0, 0, 0, 0, 3'd2, 5'b00010, 8'd10);
        add( 1, 0, 1, 1, 0, 0, 3'd1, 5'b00000, 8'd10);
        add(16, 0, 0, 1, 0, 0, 3'd2, 5'b00010, 8'd10);
        add( 1, 0, 0, 1, 0, 0, 3'd3, 5'b11010, 8'd0);
        add( 1, 0, 0, 0, 0, 1, 3'd4, 5'b01010, 8'd0);
        add( 3, 0, 0, 0, 0, 1, 3'd4, 5'b01010, 8'd3);
        add( 1, 0, 0, 0, 1, 1, 3'd6, 5'b00010, 8'd4);
        add( 4, 0, 0, 0, 0, 1, 3'd6, 5'b00010, 8'd4);
        add( 1, 0, 0, 0, 0, 0, 3'd2, 5'b00010, 8'd4);
        add( 1, 0, 0, 1, 0, 0, 3'd3, 5'b11010, 8'd0);
        add( 7, 0, 0, 0, 0, 0, 3'd3, 5'b01010, 8'd0);
`ifdef NPU_CTRL_TIMEOUT_EN
        add( 1, 0, 0, 0, 0, 0, 3'd7, 5'b00001, 8'd0);
        add( 1, 0, 1, 0, 0, 0, 3'd1, 5'b00000, 8'd0);
`else
        add( 1, 0, 0, 0, 0, 0, 3'd3, 5'b01010, 8'd0);
        add( 1, 0, 1, 0, 0, 0, 3'd3, 5'b01010, 8'd0);
`endif
        add( 1, 1, 0, 0, 0, 0, 3'd0, 5'b00000, 8'd0);
        add( 1, 0, 1, 0, 0, 0, 3'd1, 5'b00000, 8'd0);
        add(16, 0, 0, 0, 0, 0, 3'd2, 5'b00010, 8'd0);
        add( 1, 0, 0, 1, 0, 0, 3'd3, 5'b11010, 8'd0);
        add( 3, 0, 0, 0, 0, 1, 3'd4, 5'b01010, 8'd2);
        add( 1, 0, 0, 0, 1, 0, 3'd5, 5'b00110, 8'd3);
        add( 1, 0, 0, 0, 0, 0, 3'd2, 5'b00010, 8'd3);
        add( 1, 0, 0, 1, 0, 0, 3'd3, 5'b11010, 8'd0);
        add( 2, 0, 0, 0, 0, 1, 3'd4, 5'b01010, 8'd1);
        add( 1, 1, 0, 0, 0, 1, 3'd0, 5'b00000, 8'd0);

        for (int i = 0; i < ntbl; i++) begin
            for (int k = 0; k < int'(tbl[i].n); k++)
                apply(tbl[i].rs, tbl[i].ig, tbl[i].sr, tbl[i].ab, tbl[i].bz);
            check($sformatf("tbl%0d", i), {tbl[i].st, tbl[i].fl, tbl[i].run});
        end

        // run_cycles saturation over a long busy window
        apply(0, 1, 0, 0, 0);
        repeat (INIT_CYC) apply(0, 0, 0, 0, 0);
        step_chk("sat_start", 0, 0, 1, 0, 0);
        repeat (300) step_chk("sat_run", 0, 0, 0, 0, 1);
        check("sat_value", {3'd4, 5'b01010, 8'hFF});
        step_chk("sat_done", 0, 0, 0, 0, 0);
        check("sat_done_const", {3'd5, 5'b00110, 8'hFF});

        // watchdog expiring while draining
        step_chk("drain_ready", 0, 0, 0, 0, 0);
        step_chk("drain_arm", 0, 0, 1, 0, 0);
        step_chk("drain_run", 0, 0, 0, 0, 1);
        step_chk("drain_abort", 0, 0, 0, 1, 1);
        repeat (TO_CYC) step_chk("drain_wait", 0, 0, 0, 0, 1);
`ifdef NPU_CTRL_TIMEOUT_EN
        check("drain_timeout", {3'd7, 5'b00001, 8'd1});
`else
        check("drain_timeout", {3'd6, 5'b00010, 8'd1});
`endif
        step_chk("post_rst", 1, 0, 0, 0, 0);

        // randomized traffic
        bz = 1'b0;
        for (int j = 0; j < 3000; j++) begin
            rs = ($urandom_range(0, 399) == 0);
            ig = ($urandom_range(0, 39) == 0);
            sr = ($urandom_range(0, 4) == 0);
            ab = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 5) == 0) bz = ~bz;
            step_chk("random", rs, ig, sr, ab, bz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/npu_run_ctrl.md
# npu_run_ctrl

- Sequences one NPU job on the transfer clock domain: init phase, start handshake, processing enable, busy monitoring, completion, and optional timeout.
- Drives npu_init_cmplt and npu_en_processing into the cross-domain synchronizer.
- Consumes the synchronized npu_busy_sync coming back from the calculation domain.
- Sits between the host/DMA command logic and the clk_trans↔clk_cal synchronizer.

## Interface
Parameters:
- INIT_CYCLES, 16: cycles spent in the init phase before npu_init_cmplt rises; legal range 1..2^CNT_W-1.
- TIMEOUT_CYCLES, 1024: watchdog limit in ARM and DRAIN; legal range 1..2^CNT_W-1.
- CNT_W, 16: width of the init, watchdog and run counters.

Ports:
- clk_trans  in  1  controller clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- init_go  in  1  one-cycle request to (re)start the init phase.
- start_req  in  1  job start request; honoured only in READY.
- start_ack  out  1  one-cycle pulse when start_req is accepted.
- abort  in  1  cancel the running job.
- npu_init_cmplt  out  1  level; high while the NPU is initialised and no init is in progress.
- npu_en_processing  out  1  level enable for the calculation domain.
- npu_busy_sync  in  1  busy status, already synchronized into clk_trans.
- done_pulse  out  1  one-cycle pulse on normal job completion.
- err_timeout  out  1  sticky watchdog error flag.
- run_cycles  out  CNT_W  cycles busy was observed high in the last or current job; saturates at all-ones.
- state_o  out  3  current state encoding.

## Operation
The controller is an 8-state FSM.

- IDLE (0): all outputs low.
  - init_go → INIT; init counter loads INIT_CYCLES-1.
- INIT (1): npu_init_cmplt=0; counter decrements.
  - When the counter is 0 → READY.
- READY (2): npu_init_cmplt=1.
  - init_go → INIT. init_go wins over a simultaneous start_req; no ack is given.
  - Otherwise start_req → ARM with start_ack=1, npu_en_processing=1, run_cycles cleared, watchdog cleared.
- ARM (3): npu_en_processing=1; waits for npu_busy_sync=1.
  - Busy high → RUN.
  - abort → DRAIN.
  - Watchdog reaches TIMEOUT_CYCLES → ERR.
- RUN (4): npu_en_processing=1; run_cycles increments every cycle.
  - npu_busy_sync=0 → DONE, npu_en_processing=0.
  - abort with busy still high → DRAIN.
  - If abort and busy-low arrive together, completion wins: DONE.
- DONE (5): done_pulse=1 for exactly one cycle → READY.
- DRAIN (6): npu_en_processing=0; waits for npu_busy_sync=0.
  - Busy low → READY, with no done_pulse.
  - Watchdog reaches TIMEOUT_CYCLES → ERR.
- ERR (7): npu_en_processing=0, err_timeout=1, npu_init_cmplt=0.
  - Exits only via init_go → INIT, which clears err_timeout, or via rst.

General rules:
- start_req outside READY is ignored and not queued.
- abort outside ARM/RUN is ignored.
- npu_busy_sync is ignored in IDLE, INIT, READY and ERR.
- npu_en_processing is a held level, not a pulse; it stays high until busy is seen to fall or the job is aborted, which tolerates synchronizer latency.
- The watchdog counts from state entry and is cleared on every transition into ARM or DRAIN.
- run_cycles holds its value after DONE or DRAIN until the next accepted start.

## Timing
- All outputs are registered. After rst, state=IDLE and every output is 0, including run_cycles and err_timeout.
- rst has priority over every input on the same edge.
- rst mid-job drops npu_en_processing on the next edge.
- init_go sampled at edge N: state=INIT after N, and npu_init_cmplt=1 after edge N+INIT_CYCLES.
- start_req sampled in READY at edge N: start_ack and npu_en_processing are high after N.
  - start_ack falls after N+1.
- Busy falling sampled at edge M in RUN: npu_en_processing=0 and done_pulse=1 after M; READY after M+1.
- Watchdog: ERR is entered on the edge at which the count reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after ARM/DRAIN entry.

## Configuration
- NPU_CTRL_TIMEOUT_EN defined: the watchdog counter is present, the ERR state is reachable, and err_timeout behaves as specified.
- Not defined:
  - The watchdog is removed and ERR is unreachable.
  - ARM and DRAIN wait indefinitely.
  - err_timeout is tied to 0.
  - TIMEOUT_CYCLES is ignored.

## Test plan
- Reset, then init_go with INIT_CYCLES=16 → npu_init_cmplt rises exactly 16 edges after init_go; state_o=2.
- start_req in READY; busy high 3 cycles later for 10 cycles, then low → one start_ack pulse; en high until the busy-low edge; done_pulse=1 once; run_cycles=10.
- start_req with no busy response, TIMEOUT_CYCLES=8, macro on → ERR after 8 cycles; err_timeout=1; en=0. A following init_go clears err_timeout. Same stimulus with the macro off → ARM is held indefinitely.
- abort at RUN cycle 4, busy stays high 5 more cycles → en=0 next edge; DRAIN until busy low; READY with no done_pulse.
- init_go and start_req in the same READY cycle → no start_ack; npu_init_cmplt=0; INIT entered. Separately, start_req during INIT → ignored.
- rst asserted mid-RUN → next edge all outputs 0, state_o=0; run_cycles=0.
